// File: rtl/fib_arb_ctrl.sv
// rtl/fib_arb_ctrl.sv - two-requester round-robin front end sharing one iterative Fibonacci engine
module fib_arb_ctrl #(
  parameter int WIDTH = 8,
  parameter int NW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [NW-1:0]    req0_n,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [NW-1:0]    req1_n,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_value,
  output logic             rsp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             cur_ovf_q, cur_ovf_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;

  logic             grant_vld;
  logic             grant_id;
  logic [WIDTH:0]   sum;

  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else begin
      grant_id = req1_valid;
    end
  end

  assign req0_ready = (state_q == IDLE) && grant_vld && !grant_id;
  assign req1_ready = (state_q == IDLE) && grant_vld && grant_id;

  assign sum = {1'b0, prev_q} + {1'b0, cur_q};

  // ovf tracks whether true prev exceeds WIDTH bits; cur_ovf does the same for cur,
  // so a carry into cur only reaches rsp_ovf once that value has shifted into prev.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    cur_ovf_d = cur_ovf_q;
    owner_d   = owner_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          prev_d    = '0;
          cur_d     = {{(WIDTH-1){1'b0}}, 1'b1};
          cnt_d     = grant_id ? req1_n : req0_n;
          ovf_d     = 1'b0;
          cur_ovf_d = 1'b0;
          owner_d   = grant_id;
          last_d    = grant_id;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          prev_d    = cur_q;
          cur_d     = sum[WIDTH-1:0];
          cnt_d     = cnt_q - 1'b1;
          ovf_d     = ovf_q | cur_ovf_q;
          cur_ovf_d = cur_ovf_q | sum[WIDTH];
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      cur_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      cur_ovf_q <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      cur_ovf_q <= cur_ovf_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_value = rsp_valid ? prev_q : '0;
  assign rsp_id    = rsp_valid ? owner_q : 1'b0;
  assign rsp_ovf   = rsp_valid ? ovf_q : 1'b0;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fib_arb_ctrl.sv
// tb/tb_fib_arb_ctrl.sv - directed vector bench for fib_arb_ctrl
module tb_fib_arb_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [4:0] req0_n, req1_n;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
  logic [7:0] rsp_value;

  int tests = 0;
  int fails = 0;

  fib_arb_ctrl #(.WIDTH(8), .NW(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_n(req0_n), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_n(req1_n), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_value(rsp_value), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         id;
    logic [4:0] n;
    logic [7:0] val;
    bit         ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after an accept edge; returns edges until rsp_valid, sampled at negedge.
  task automatic wait_rsp(output int lat, output int val, output int ovf, output int id);
    lat = -1; val = -1; ovf = -1; id = -1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin
        lat = k; val = rsp_value; ovf = rsp_ovf; id = rsp_id;
        break;
      end
    end
  endtask

  // Called at a negedge with the DUT idle and no other request pending.
  task automatic job(input bit id, input logic [4:0] n,
                     output int lat, output int val, output int ovf, output int rid);
    if (id) begin req1_valid = 1'b1; req1_n = n; end
    else    begin req0_valid = 1'b1; req0_n = n; end
    #1;
    check("ready_on_request", id ? req1_ready : req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(lat, val, ovf, rid);
  endtask

  initial begin
    int lat, val, ovf, rid;

    vecs[0] = '{0, 5'd10, 8'd55,  0};
    vecs[1] = '{0, 5'd0,  8'd0,   0};
    vecs[2] = '{1, 5'd1,  8'd1,   0};
    vecs[3] = '{0, 5'd13, 8'd233, 0};
    vecs[4] = '{1, 5'd14, 8'd121, 1};
    vecs[5] = '{0, 5'd20, 8'd109, 1};
    vecs[6] = '{1, 5'd12, 8'd144, 0};
    vecs[7] = '{0, 5'd6,  8'd8,   0};
    vecs[8] = '{1, 5'd9,  8'd34,  0};
    vecs[9] = '{1, 5'd5,  8'd5,   0};

    reset = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_n = 5'd3;
    req1_valid = 1'b1; req1_n = 5'd4;
    @(negedge clk);
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_value", rsp_value, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_ovf", rsp_ovf, 0);
    check("reset_busy", busy, 0);
    check("reset_tie_ready0", req0_ready, 1);
    check("reset_tie_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("reset_no_valid_ready0", req0_ready, 0);
    check("reset_no_valid_ready1", req1_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      job(vecs[i].id, vecs[i].n, lat, val, ovf, rid);
      check($sformatf("vec%0d_latency", i), lat, int'(vecs[i].n) + 1);
      check($sformatf("vec%0d_value", i), val, int'(vecs[i].val));
      check($sformatf("vec%0d_ovf", i), ovf, int'(vecs[i].ovf));
      check($sformatf("vec%0d_id", i), rid, int'(vecs[i].id));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), busy, 0);
    end

    // Round-robin with both requesters held valid across three jobs.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b1; req0_n = 5'd5;
    req1_valid = 1'b1; req1_n = 5'd7;
    #1;
    check("tie1_ready0", req0_ready, 1);
    check("tie1_ready1", req1_ready, 0);
    @(posedge clk);
    wait_rsp(lat, val, ovf, rid);
    check("tie1_value", val, 5);
    check("tie1_id", rid, 0);
    check("tie1_latency", lat, 6);
    check("done_ready0", req0_ready, 0);
    check("done_ready1", req1_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("tie2_ready0", req0_ready, 0);
    check("tie2_ready1", req1_ready, 1);
    @(posedge clk);
    wait_rsp(lat, val, ovf, rid);
    check("tie2_value", val, 13);
    check("tie2_id", rid, 1);
    @(posedge clk);
    @(negedge clk);
    check("tie3_ready0", req0_ready, 1);
    check("tie3_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Backpressure in DONE, with a competing request that must wait.
    rsp_ready = 1'b0;
    job(0, 5'd12, lat, val, ovf, rid);
    check("hold_value_first", val, 144);
    req1_valid = 1'b1; req1_n = 5'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", c), rsp_valid, 1);
      check($sformatf("hold%0d_value", c), rsp_value, 144);
      check($sformatf("hold%0d_id", c), rsp_id, 0);
      check($sformatf("hold%0d_ready1", c), req1_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hold_release_busy", busy, 0);
    check("hold_release_valid", rsp_valid, 0);
    check("hold_release_ready1", req1_ready, 1);
    req1_valid = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a long job.
    req0_valid = 1'b1; req0_n = 5'd20;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrun_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_valid", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    job(0, 5'd6, lat, val, ovf, rid);
    check("after_reset_value", val, 8);
    check("after_reset_latency", lat, 7);
    @(posedge clk);
    @(negedge clk);

    // Index input changes after acceptance.
    req1_valid = 1'b1; req1_n = 5'd9;
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    req1_n = 5'd3;
    wait_rsp(lat, val, ovf, rid);
    check("nchange_value", val, 34);
    check("nchange_id", rid, 1);
    check("nchange_latency", lat, 10);
    @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
